prefetch_queue: RTL and testbench

Parametrised instruction prefetch unit for the 80x86 core. It merges the prefetch address generator and the byte FIFO into one block. It fetches 16-bit words from the instruction bus at CS:IP, pushes 1 or 2 bytes per ack into a configurable-depth byte queue, and presents bytes to the decode consumers (ModRM/immediate/microcode readers). Unlike the previous generation, it supports:
- odd-IP alignment
- redirect while a fetch is in flight, with the stale ack discarded
- 16-bit IP wrap inside the segment
- a level output for the consumers

---
 rtl/prefetch_queue_pkg.sv | 19 +
 rtl/prefetch_byte_fifo.sv | 73 +++++++
 rtl/prefetch_queue.sv | 122 ++++++++++++
 tb/tb_prefetch_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared state encoding, reset defaults and address helper for the 80x86
// instruction prefetch queue.
package prefetch_queue_pkg;

   typedef logic [1:0] pq_state_t;

   localparam pq_state_t PQ_IDLE    = 2'd0;
   localparam pq_state_t PQ_FETCH   = 2'd1;
   localparam pq_state_t PQ_DISCARD = 2'd2;

   localparam logic [15:0] PQ_RESET_CS = 16'hffff;
   localparam logic [15:0] PQ_RESET_IP = 16'h0000;

   // Real-mode physical address, wrapping at 1 MiB.
   function automatic logic [19:0] pq_phys_addr(input logic [15:0] cs, input logic [15:0] ip);
      return {cs, 4'h0} + {4'h0, ip};
   endfunction

endpackage

// File: rtl/prefetch_byte_fifo.sv
// Byte queue for the prefetch unit: 0/1/2-byte write port, 1-byte read port
// and a flush that empties it in one cycle.
module prefetch_byte_fifo #(
   parameter int unsigned DEPTH = 6
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush_i,
   input  logic [1:0]                   wr_count_i,
   input  logic [15:0]                  wr_data_i,
   input  logic                         rd_en_i,
   output logic [7:0]                   rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
   logic [LW-1:0] level_q, level_d;
   logic          pop;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input int unsigned inc);
      int unsigned sum;
      sum = 32'(ptr) + inc;
      if (sum >= DEPTH) begin
         sum = sum - DEPTH;
      end
      return PW'(sum);
   endfunction

   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];
   assign pop       = rd_en_i && !empty_o && !flush_i;
   assign wr_ptr_p1 = ptr_add(wr_ptr_q, 32'd1);

   always_comb begin
      wr_ptr_d = ptr_add(wr_ptr_q, 32'(wr_count_i));
      rd_ptr_d = pop ? ptr_add(rd_ptr_q, 32'd1) : rd_ptr_q;
      level_d  = level_q + LW'(wr_count_i) - LW'(pop);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!flush_i && wr_count_i != 2'd0) begin
         mem_q[wr_ptr_q] <= wr_data_i[7:0];
      end
      if (!flush_i && wr_count_i == 2'd2) begin
         mem_q[wr_ptr_p1] <= wr_data_i[15:8];
      end
   end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch unit: fetches 16-bit words at CS:IP into a byte queue,
// handling odd IP, 16-bit IP wrap and redirects with an outstanding fetch.
module prefetch_queue
   import prefetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 6,
   parameter logic [15:0] RESET_CS = PQ_RESET_CS,
   parameter logic [15:0] RESET_IP = PQ_RESET_IP
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [15:0]                  new_cs,
   input  logic [15:0]                  new_ip,
   input  logic                         load_new_ip,
   input  logic                         rd_en,
   output logic [7:0]                   rd_data,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         mem_access,
   input  logic                         mem_ack,
   output logic [18:0]                  mem_address,
   input  logic [15:0]                  mem_data
);

   pq_state_t   state_q, state_d;
   logic [15:0] fetch_cs_q, fetch_cs_d;
   logic [15:0] fetch_ip_q, fetch_ip_d;
   logic        mem_access_q, mem_access_d;
   logic [18:0] mem_address_q, mem_address_d;
   logic [19:0] phys_addr;
   logic        have_room;
   logic [1:0]  wr_count;
   logic [15:0] wr_data;

   assign phys_addr   = pq_phys_addr(fetch_cs_q, fetch_ip_q);
   assign have_room   = (32'(level) + 32'd2) <= DEPTH;
   assign mem_access  = mem_access_q;
   assign mem_address = mem_address_q;

   always_comb begin
      state_d       = state_q;
      fetch_cs_d    = fetch_cs_q;
      fetch_ip_d    = fetch_ip_q;
      mem_access_d  = mem_access_q;
      mem_address_d = mem_address_q;
      wr_count      = 2'd0;
      wr_data       = mem_data;
      unique case (state_q)
         PQ_IDLE: begin
            if (have_room && !load_new_ip) begin
               state_d       = PQ_FETCH;
               mem_access_d  = 1'b1;
               mem_address_d = phys_addr[19:1];
            end
         end
         PQ_FETCH: begin
            if (mem_ack) begin
               state_d      = PQ_IDLE;
               mem_access_d = 1'b0;
               if (!load_new_ip) begin
                  // An odd IP only wants the high byte of the word.
                  if (fetch_ip_q[0]) begin
                     wr_count   = 2'd1;
                     wr_data    = {8'h00, mem_data[15:8]};
                     fetch_ip_d = fetch_ip_q + 16'd1;
                  end else begin
                     wr_count   = 2'd2;
                     fetch_ip_d = fetch_ip_q + 16'd2;
                  end
               end
            end else if (load_new_ip) begin
               state_d = PQ_DISCARD;
            end
         end
         PQ_DISCARD: begin
            if (mem_ack) begin
               state_d      = PQ_IDLE;
               mem_access_d = 1'b0;
            end
         end
         default: begin
            state_d      = PQ_IDLE;
            mem_access_d = 1'b0;
         end
      endcase
      if (load_new_ip) begin
         fetch_cs_d = new_cs;
         fetch_ip_d = new_ip;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= PQ_IDLE;
         fetch_cs_q    <= RESET_CS;
         fetch_ip_q    <= RESET_IP;
         mem_access_q  <= 1'b0;
         mem_address_q <= '0;
      end else begin
         state_q       <= state_d;
         fetch_cs_q    <= fetch_cs_d;
         fetch_ip_q    <= fetch_ip_d;
         mem_access_q  <= mem_access_d;
         mem_address_q <= mem_address_d;
      end
   end

   prefetch_byte_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush_i   (load_new_ip),
      .wr_count_i(wr_count),
      .wr_data_i (wr_data),
      .rd_en_i   (rd_en),
      .rd_data_o (rd_data),
      .level_o   (level),
      .empty_o   (empty)
   );

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: a transaction-level model predicts each
// cycle's bus and queue state; a monitor compares the DUT against it.
module tb_prefetch_queue;

   localparam int unsigned DEPTH    = 6;
   localparam logic [15:0] RESET_CS = 16'hffff;
   localparam logic [15:0] RESET_IP = 16'h0000;
   localparam int unsigned LW       = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   new_cs, new_ip;
   logic          load_new_ip, rd_en;
   logic [7:0]    rd_data;
   logic          empty;
   logic [LW-1:0] level;
   logic          mem_access, mem_ack;
   logic [18:0]   mem_address;
   logic [15:0]   mem_data;

   prefetch_queue #(
      .DEPTH   (DEPTH),
      .RESET_CS(RESET_CS),
      .RESET_IP(RESET_IP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .new_cs     (new_cs),
      .new_ip     (new_ip),
      .load_new_ip(load_new_ip),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .level      (level),
      .mem_access (mem_access),
      .mem_ack    (mem_ack),
      .mem_address(mem_address),
      .mem_data   (mem_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        busy;
      logic [18:0] addr;
      int          lvl;
      logic [7:0]  head;
      logic        rd0;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  m_q[$];
   logic        m_valid = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_stale = 1'b0;
   logic        m_rd0 = 1'b0;
   logic [15:0] m_cs, m_ip;
   logic [18:0] m_addr = '0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [18:0] word_addr(input logic [15:0] cs, input logic [15:0] ip);
      int p;
      p = (int'(cs) * 16 + int'(ip)) % 1048576;
      return 19'(p / 2);
   endfunction

   // One clock of stimulus; the model advances to the state the DUT holds next cycle.
   task automatic cycle(input logic rst, input logic rd, input logic ld, input logic [15:0] cs,
                        input logic [15:0] ip, input logic ack, input logic [15:0] data);
      exp_t e;
      logic room;
      @(negedge clk);
      reset = rst; rd_en = rd; load_new_ip = ld; new_cs = cs; new_ip = ip;
      mem_ack = ack; mem_data = data;
      if (m_valid) begin
         e.busy = m_busy; e.addr = m_addr; e.lvl = m_q.size();
         e.head = (m_q.size() > 0) ? m_q[0] : 8'h00; e.rd0 = m_rd0;
         exp_q.push_back(e);
      end
      if (rst) begin
         m_q.delete(); m_busy = 0; m_stale = 0; m_cs = RESET_CS; m_ip = RESET_IP;
         m_valid = 1; m_rd0 = 1;
      end else begin
         m_rd0 = 0;
         room = (int'(DEPTH) - m_q.size()) >= 2;
         if (rd && !ld && m_q.size() > 0) void'(m_q.pop_front());
         if (m_busy) begin
            if (ack) begin
               if (!m_stale && !ld) begin
                  if (m_ip[0]) begin
                     m_q.push_back(data[15:8]); m_ip = m_ip + 16'd1;
                  end else begin
                     m_q.push_back(data[7:0]); m_q.push_back(data[15:8]); m_ip = m_ip + 16'd2;
                  end
               end
               m_busy = 0; m_stale = 0;
            end else if (ld) begin
               m_stale = 1;
            end
         end else if (room && !ld) begin
            m_busy = 1; m_addr = word_addr(m_cs, m_ip);
         end
         if (ld) begin
            m_cs = cs; m_ip = ip; m_q.delete();
         end
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic ack_with(input logic [15:0] data);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, data);
   endtask

   task automatic redirect(input logic [15:0] cs, input logic [15:0] ip, input logic ack);
      cycle(1'b0, 1'b0, 1'b1, cs, ip, ack, 16'hdead);
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   task automatic wait_busy(input string name);
      int n;
      n = 0;
      while (!m_busy && n < 10) begin
         idle(); n++;
      end
      if (!m_busy) begin
         n_checks++;
         $display("FAIL %s: no access within 10 cycles, expected one", name);
      end
   endtask

   // Monitor: compares the DUT every cycle against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_access", 32'(mem_access), 32'(e.busy));
            check("level", 32'(level), e.lvl);
            check("empty", 32'(empty), 32'(e.lvl == 0));
            if (e.busy) check("mem_address", 32'(mem_address), 32'(e.addr));
            if (e.lvl > 0) check("rd_data", 32'(rd_data), 32'(e.head));
            if (e.rd0) check("rd_data_reset", 32'(rd_data), 32'h0);
         end
      end
   end

   initial begin
      reset = 1; rd_en = 0; load_new_ip = 0; new_cs = 0; new_ip = 0; mem_ack = 0; mem_data = 0;
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

      // Reset vector fetch and byte order
      wait_busy("s1_wait"); settle();
      check("s1_addr", 32'(mem_address), 32'h7fff8);
      ack_with(16'h1234); settle();
      check("s1_rd0", 32'(rd_data), 32'h34);
      check("s1_level", 32'(level), 32'd2);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); settle();
      check("s1_rd1", 32'(rd_data), 32'h12);

      // Redirect with fetch outstanding, stale ack, then odd IP
      redirect(16'h0000, 16'h0101, 1'b0); settle();
      check("s4_flush", 32'(level), 32'd0);
      check("s4_held", 32'(mem_access), 32'd1);
      ack_with(16'hdead); settle();
      check("s4_stale", 32'(empty), 32'd1);
      wait_busy("s2_wait"); settle();
      check("s2_addr", 32'(mem_address), 32'h00080);
      ack_with(16'hbbaa); settle();
      check("s2_level", 32'(level), 32'd1);
      check("s2_byte", 32'(rd_data), 32'hbb);
      wait_busy("s2_wait2"); settle();
      check("s2_next", 32'(mem_address), 32'h00081);

      // Fill without popping
      redirect(16'h2000, 16'h0000, 1'b0);
      ack_with(16'h0000);
      for (int i = 0; i < int'(DEPTH) / 2; i++) begin
         wait_busy("s3_wait"); ack_with(16'($urandom));
      end
      repeat (4) idle();
      settle();
      check("s3_full", 32'(level), DEPTH);
      check("s3_noacc", 32'(mem_access), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      idle(); idle(); settle();
      check("s3_pop1", 32'(mem_access), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      idle(); settle();
      check("s3_pop2", 32'(mem_access), 32'd1);

      // Redirect coinciding with ack, then push+pop together
      redirect(16'h0000, 16'h0201, 1'b1); settle();
      check("s5_drop", 32'(level), 32'd0);
      wait_busy("s5_a"); ack_with(16'h2211);
      wait_busy("s5_b"); ack_with(16'h4433);
      wait_busy("s5_c"); settle();
      check("s5_lvl3", 32'(level), 32'd3);
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h6655); settle();
      check("s5_lvl4", 32'(level), 32'd4);

      // IP wrap inside the segment
      redirect(16'h1000, 16'hfffe, 1'b0);
      wait_busy("s6_a"); settle();
      check("s6_addr0", 32'(mem_address), 32'h0ffff);
      ack_with(16'h8877);
      wait_busy("s6_b"); settle();
      check("s6_addr1", 32'(mem_address), 32'h08000);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [15:0] rcs, rip;
         rcs = 16'($urandom);
         rip = 16'($urandom);
         if ($urandom_range(0, 3) == 0) rip = 16'hfffe + 16'($urandom_range(0, 1));
         cycle($urandom_range(0, 599) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 29) == 0, rcs, rip, $urandom_range(0, 2) == 0, 16'($urandom));
      end
      idle(); idle();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
